// File: rtl/ihs_pkg.sv
// Shared definitions for the fetch front end: word width, opcode encodings
// and the fetch FSM state type.
package ihs_pkg;

   localparam int XLEN = 16;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_OUT = 3'b100;
   localparam logic [2:0] OP_LDI = 3'b101;
   localparam logic [2:0] OP_BNE = 3'b110;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next fetch address and static branch prediction for the word being captured.
// Optional macro FETCH_BTFN_EN: predict backward bne as taken.
module fetch_next_pc
   import ihs_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] next_pc,
   output logic            pred_taken
);

`ifdef FETCH_BTFN_EN
   logic            w_is_bwd_bne;
   logic [XLEN-1:0] w_target;
   logic            w_unused_bits;

   // A negative imm10 means a backward branch, which is predicted taken.
   assign w_is_bwd_bne  = (instr[15:13] == OP_BNE) && instr[9];
   assign w_target      = pc + {{6{instr[9]}}, instr[9:0]};
   assign next_pc       = w_is_bwd_bne ? w_target : pc + 16'd1;
   assign pred_taken    = w_is_bwd_bne;
   assign w_unused_bits = ^instr[12:10];
`else
   logic w_unused_instr;

   assign next_pc        = pc + 16'd1;
   assign pred_taken     = 1'b0;
   assign w_unused_instr = ^instr;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: BOOT/RUN/HALT FSM, valid/ready output register,
// redirect and halt handling. Optional macro FETCH_BTFN_EN (see fetch_next_pc).
module fetch_unit
   import ihs_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic [15:0]  imem_addr,
   input  logic [15:0]  imem_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [15:0]  out_instr,
   output logic [15:0]  out_pc,
   output logic         out_pred_taken,
   input  logic         redirect_valid,
   input  logic [15:0]  redirect_pc,
   input  logic         halt_req,
   output logic         halted,
   output fetch_state_e dbg_state
);

   // Output handshake: a word moves to decode on every edge where
   // out_valid && out_ready; while out_valid && !out_ready all outputs hold.

   fetch_state_e r_state, w_state_nxt;
   logic [15:0]  r_pc, w_pc_nxt;
   logic         r_out_valid, w_valid_nxt;
   logic [15:0]  r_out_instr, w_instr_nxt;
   logic [15:0]  r_out_pc, w_opc_nxt;
   logic         r_out_pred, w_pred_nxt;
   logic [15:0]  w_next_pc;
   logic         w_pred_taken;

   fetch_next_pc u_next_pc (
      .pc         (r_pc),
      .instr      (imem_data),
      .next_pc    (w_next_pc),
      .pred_taken (w_pred_taken)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_BOOT;
         r_pc        <= RESET_PC;
         r_out_valid <= 1'b0;
         r_out_instr <= 16'h0000;
         r_out_pc    <= 16'h0000;
         r_out_pred  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_out_valid <= w_valid_nxt;
         r_out_instr <= w_instr_nxt;
         r_out_pc    <= w_opc_nxt;
         r_out_pred  <= w_pred_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_valid_nxt = r_out_valid;
      w_instr_nxt = r_out_instr;
      w_opc_nxt   = r_out_pc;
      w_pred_nxt  = r_out_pred;
      // Redirect wins over everything once out of BOOT; any presented word is dropped.
      if ((r_state != ST_BOOT) && redirect_valid) begin
         w_state_nxt = ST_RUN;
         w_pc_nxt    = redirect_pc;
         w_valid_nxt = 1'b0;
         w_pred_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
               if (halt_req) begin
                  w_state_nxt = ST_HALT;
                  if (r_out_valid && out_ready) w_valid_nxt = 1'b0;
               end else if (!r_out_valid || out_ready) begin
                  w_valid_nxt = 1'b1;
                  w_instr_nxt = imem_data;
                  w_opc_nxt   = r_pc;
                  w_pred_nxt  = w_pred_taken;
                  w_pc_nxt    = w_next_pc;
               end
            end
            ST_HALT: begin
               if (r_out_valid && out_ready) w_valid_nxt = 1'b0;
            end
            default: w_state_nxt = ST_BOOT;
         endcase
      end
   end

   assign imem_addr      = r_pc;
   assign out_valid      = r_out_valid;
   assign out_instr      = r_out_instr;
   assign out_pc         = r_out_pc;
   assign out_pred_taken = r_out_pred;
   assign halted         = (r_state == ST_HALT) && !r_out_valid;
   assign dbg_state      = r_state;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC loaded on reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port imem_addr, output, 16: fetch address to the combinational instruction memory; equals the pc register.
REQ-005 SHALL have port imem_data, input, 16: instruction word returned combinationally for imem_addr.
REQ-006 SHALL have port out_valid, output, 1: out_instr/out_pc/out_pred_taken hold a fetched instruction.
REQ-007 SHALL have port out_ready, input, 1: decode accepts the output this cycle.
REQ-008 SHALL have port out_instr, output, 16: fetched instruction word.
REQ-009 SHALL have port out_pc, output, 16: address out_instr was fetched from.
REQ-010 SHALL have port out_pred_taken, output, 1: fetch predicted the bne as taken.
REQ-011 SHALL have port redirect_valid, input, 1: redirect request from downstream (branch resolve or mispredict).
REQ-012 SHALL have port redirect_pc, input, 16: new fetch address.
REQ-013 SHALL have port halt_req, input, 1: level request to stop fetching.
REQ-014 SHALL have port halted, output, 1: fetch is stopped and the output is drained.

Function
REQ-015 SHALL implement a three-state FSM: BOOT, RUN and HALT.
REQ-016 BOOT SHALL last exactly one cycle after rst_n deasserts and then go to RUN, with no capture during BOOT.
REQ-017 In RUN with redirect_valid=0 and (out_valid=0 or out_ready=1), the block SHALL load out_instr<=imem_data, out_pc<=pc and out_valid<=1, and set pc<=next_pc.
REQ-018 In RUN with out_valid=1 and out_ready=0, the block SHALL hold pc and all outputs stable (no drop, no duplicate).
REQ-019 A transfer SHALL complete on any cycle where out_valid=1 and out_ready=1, and when no new capture occurs that cycle, out_valid SHALL be cleared on the following edge.
REQ-020 Latency SHALL be one cycle from pc==A to out_instr==rom[A], with sustained throughput of 1 instruction/cycle while out_ready=1.
REQ-021 next_pc SHALL be pc+1 computed modulo 2^16, so 16'hFFFF wraps to 16'h0000.
REQ-022 redirect_valid SHALL have priority over capture, handshake and halt in any state except BOOT: pc<=redirect_pc, out_valid<=0, out_pred_taken<=0, state<=RUN.
REQ-023 When redirect_valid and out_ready are high in the same cycle, the current output SHALL count as consumed and the block SHALL capture nothing that cycle.
REQ-024 halt_req=1 in RUN SHALL set state to HALT, stop further captures and keep pc, while any pending out_valid stays presented until accepted.
REQ-025 halted SHALL be 1 iff state==HALT and out_valid==0.
REQ-026 HALT SHALL be left only by redirect_valid, whatever the level of halt_req.
REQ-027 Instruction format SHALL be opcode=instr[15:13], with bne=3'b110 and imm10=instr[9:0] signed; the branch target SHALL be pc+sext(imm10), modulo 2^16.

Reset
REQ-028 While rst_n=0, the block SHALL hold pc=RESET_PC, state=BOOT, out_valid=0, out_instr=16'h0000, out_pc=16'h0000, out_pred_taken=0 and halted=0.
REQ-029 Reset asserted mid-transfer SHALL discard the pending instruction immediately, without waiting for a clock edge.

Configuration
REQ-030 With macro FETCH_BTFN_EN defined, capturing an instruction with opcode==bne and imm10[9]==1 SHALL set next_pc=branch target and out_pred_taken=1; all other instructions SHALL follow REQ-021 with out_pred_taken=0.
REQ-031 Without FETCH_BTFN_EN, next_pc SHALL always be pc+1, out_pred_taken SHALL be tied to 0, and no predecode logic SHALL exist.

Structure
REQ-032 Shared package ihs_pkg SHALL hold XLEN=16, the opcode constants (ADD, SUB, OUT, LDI, BNE) and the fetch FSM state enum.
REQ-033 next-PC and predecode logic SHALL be a sub-module named fetch_next_pc (inputs pc and instr; outputs next_pc and pred_taken).

Verification
REQ-034 Reset scenario: rst_n low, then high, with the standard program loaded -> one BOOT cycle, then out_pc sequence 0,1,2,... and out_instr at pc 0 == 16'hA005.
REQ-035 Backpressure scenario: out_ready=0 for 3 cycles while out_pc=2 -> outputs hold 2/16'hA800; on release, the next value is pc 3 with no skip.
REQ-036 Prediction scenario (FETCH_BTFN_EN): capture at pc 6 (16'hC7FD) -> out_pred_taken=1 and the next out_pc=3; without the macro the next out_pc=7.
REQ-037 Redirect scenario: redirect_valid with redirect_pc=7 and out_valid=1 -> out_valid=0 on the next cycle, and the following output has out_pc=7 and instr 16'h8800.
REQ-038 Halt scenario: halt_req during RUN with out_ready=0 -> halted=0 until the output is accepted, then halted=1 with pc frozen; redirect_pc=0 then resumes at 0.
REQ-039 Wrap scenario: redirect_pc=16'hFFFF -> after the capture at 16'hFFFF, imem_addr==16'h0000.
